uart_rx_os: RTL and testbench

- Oversampling UART receiver that consumes the serial line driven by the team's UART transmitter.
- Frame format: start (0), N data bits MSB-first, parity bit, stop (1).
- Deframes each frame, checks parity and stop bit, and presents the byte on a valid/ready interface to the downstream logic.
- The baud clock is derived internally from clk via a per-bit clock count; no external strobe.

---
 rtl/uart_rx_os.sv | 110 +++++++++++
 tb/tb_uart_rx_os.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (start, N data bits MSB-first, parity, stop) with a valid/ready output.
module uart_rx_os #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    input  logic         rx_ready,
    output logic         parity_err,
    output logic         frame_err,
    output logic         overrun_err,
    output logic         busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT % 2 != 0 || CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("CLKS_PER_BIT must be even and >= 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

    state_t        st;
    logic          s1, rx_s, rx_q, fall, perr;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bits;
    logic [N-1:0]  sh;

    assign fall = rx_q & ~rx_s;

    // Counter runs freely and wraps; it is cleared on entry to START and at mid start bit,
    // so every later wrap point lands in the middle of a bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1          <= 1'b1;
            rx_s        <= 1'b1;
            rx_q        <= 1'b1;
            st          <= IDLE;
            cnt         <= '0;
            bits        <= '0;
            sh          <= '0;
            perr        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            s1          <= rx;
            rx_s        <= s1;
            rx_q        <= rx_s;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            cnt         <= cnt == LAST ? '0 : cnt + 1'b1;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (st)
                IDLE: if (fall) begin
                    st   <= START;
                    busy <= 1'b1;
                    cnt  <= '0;
                end
                START: if (cnt == MID) begin
                    cnt  <= '0;
                    bits <= '0;
                    st   <= rx_s ? IDLE : DATA;
                    busy <= ~rx_s;
                end
                DATA: if (cnt == LAST) begin
                    sh   <= N'({sh, rx_s});
                    bits <= bits + 1'b1;
                    if (bits == BW'(N - 1)) st <= PARITY;
                end
                PARITY: if (cnt == LAST) begin
                    perr <= (^{sh, rx_s}) != (PARITY_ODD != 0);
                    st   <= STOP;
                end
                STOP: if (cnt == LAST) begin
                    if (rx_s) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        if (rx_valid && !rx_ready) overrun_err <= 1'b1;
                        else begin
                            rx_data    <= sh;
                            parity_err <= perr;
                            rx_valid   <= 1'b1;
                        end
                    end else begin
                        frame_err <= 1'b1;
                        st        <= BRK;
                    end
                end
                BRK: if (rx_s) begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed and random frames checked against a cycle-level output model.
module tb_uart_rx_os;
    localparam int N    = 8;
    localparam int CPB  = 16;
    localparam int PODD = 1;
    localparam int L    = 2 + CPB / 2 + (N + 2) * CPB + 1;

    logic         clk = 1'b0, rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
    logic [N-1:0] rx_data;
    logic         rx_valid, parity_err, frame_err, overrun_err, busy;

    uart_rx_os #(.N(N), .CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           c;
        logic         fe;
        logic [N-1:0] d;
        logic         pe;
    } ev_t;

    ev_t          ev_q[$];
    int           cyc = 0, n_cmp = 0, n_fail = 0, n_ovr = 0;
    bit           run = 0, rand_ready = 0;
    logic         m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    logic [N-1:0] m_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Output-side model: each frame is a completion event at a known posedge.
    always @(posedge clk) begin : model
        int   nc;
        logic pre, v, pe, fe, ov;
        logic [N-1:0] d;
        ev_t  e;
        nc = cyc + 1;
        cyc <= nc;
        pre = m_valid; v = m_valid; d = m_data; pe = m_perr; fe = 1'b0; ov = 1'b0;
        if (rst) begin
            v = 1'b0; d = '0; pe = 1'b0;
            ev_q.delete();
        end else begin
            if (pre && rx_ready) v = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].c == nc) begin
                e = ev_q.pop_front();
                if (e.fe) fe = 1'b1;
                else if (pre && !rx_ready) ov = 1'b1;
                else begin v = 1'b1; d = e.d; pe = e.pe; end
            end
        end
        m_valid <= v; m_data <= d; m_perr <= pe; m_ferr <= fe; m_ovr <= ov;
    end

    always @(negedge clk) if (run) begin
        chk("rx_valid", rx_valid, m_valid);
        chk("frame_err", frame_err, m_ferr);
        chk("overrun_err", overrun_err, m_ovr);
        if (m_valid) begin
            chk("rx_data", rx_data, m_data);
            chk("parity_err", parity_err, m_perr);
        end
        if (overrun_err) n_ovr++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_frame(input logic [N-1:0] d, input logic p, input logic stop);
        ev_t e;
        e.c  = cyc + L;
        e.fe = ~stop;
        e.d  = d;
        e.pe = (($countones(d) + int'(p)) % 2) != PODD;
        ev_q.push_back(e);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = N - 1; i >= 0; i--) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rx = p;
        repeat (CPB) tick();
        rx = stop;
        repeat (CPB) tick();
    endtask

    initial begin
        int t0;
        logic [N-1:0] d;
        logic p, stop;
        repeat (3) tick();
        rst = 1'b0;
        run = 1;
        chk("reset busy", busy, 0);
        chk("reset rx_data", rx_data, 0);
        repeat (4) tick();

        // clean 0xA5, exact latency
        rx_ready = 1'b1;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (170) tick();
                chk("lat valid@170", rx_valid, 0);
                tick();
                chk("lat valid@171", rx_valid, 1);
                chk("lat data", rx_data, 8'hA5);
                chk("lat perr", parity_err, 0);
                tick();
                chk("lat valid@172", rx_valid, 0);
            end
        join
        rx_ready = 1'b0;
        repeat (CPB) tick();

        // wrong parity still delivered
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("par valid", rx_valid, 1);
        chk("par data", rx_data, 8'h3C);
        chk("par perr", parity_err, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (CPB) tick();

        // stop bit 0, line held low
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (40 * CPB) tick();
        chk("break busy", busy, 1);
        rx = 1'b1;
        repeat (CPB) tick();
        chk("break released", busy, 0);
        rx_ready = 1'b1;
        send_frame(8'h0F, 1'b1, 1'b1);
        rx_ready = 1'b0;
        repeat (CPB) tick();

        // start glitch
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        chk("glitch busy", busy, 1);
        repeat (CPB) tick();
        chk("glitch idle", busy, 0);
        repeat (CPB) tick();

        // back-to-back with consumer stalled
        n_ovr = 0;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("ovr held data", rx_data, 8'h11);
        chk("ovr pulses", n_ovr, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("ovr drained", rx_valid, 0);
        repeat (CPB) tick();

        // reset mid-DATA of 0x99
        t0 = 0;
        d = 8'h99;
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = N - 1; i >= N - 3; i--) begin
            rx = d[i];
            repeat (CPB) tick();
        end
        rst = 1'b1;
        rx = 1'b1;
        tick();
        chk("rst busy", busy, 0);
        chk("rst valid", rx_valid, 0);
        chk("rst data", rx_data, 0);
        chk("rst ferr", frame_err, 0);
        rst = 1'b0;
        repeat (CPB) tick();
        send_frame(8'h81, 1'b1, 1'b1);
        chk("post-rst data", rx_data, 8'h81);
        chk("post-rst valid", rx_valid, 1);

        // random traffic with random consumer
        rand_ready = 1;
        for (int k = 0; k < 30; k++) begin
            d    = N'($urandom);
            p    = 1'($urandom_range(0, 1));
            stop = $urandom_range(0, 4) != 0;
            send_frame(d, p, stop);
            if (!stop) begin
                repeat ($urandom_range(0, 4 * CPB)) tick();
                rx = 1'b1;
                repeat (CPB) tick();
            end else if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3 * CPB)) tick();
            end
        end
        repeat (L) tick();
        rand_ready = 0;
        rx_ready = 1'b1;
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
